// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Definitions shared by the ALU dispatcher and its request FIFO:
//   - datapath, opcode and tag widths
//   - ALU opcode encoding
//   - dispatcher FSM state encoding
//   - packed request record held in the FIFO
//   - small helper function that flags the reserved opcode
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int DATA_W     = 19;
    localparam int OP_W       = 3;
    localparam int TAG_W      = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int PAYLOAD_W  = OP_W + DATA_W + DATA_W + TAG_W;
    localparam int OPS_W      = 16;

    // ALU opcodes as they appear on req_op and alu_ctrl
    typedef enum logic [OP_W-1:0] {
        OP_SUB  = 3'b000,
        OP_ADD  = 3'b001,
        OP_MUL  = 3'b010,
        OP_DIV3 = 3'b011,
        OP_AND  = 3'b100,
        OP_SHL  = 3'b101,
        OP_SHR  = 3'b110,
        OP_RSVD = 3'b111
    } alu_op_e;

    // Dispatcher sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DRIVE = 2'b01,
        ST_RESP  = 2'b10
    } state_e;

    // One queued request; field order fixes the FIFO payload bit layout
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [TAG_W-1:0]  tag;
    } req_t;

    // True when the opcode is the reserved encoding
    function automatic logic is_reserved(input logic [OP_W-1:0] op);
        return (op == OP_RSVD);
    endfunction

endpackage

// File: rtl/req_fifo.sv
// -----------------------------------------------------------------------------
// req_fifo
// Small synchronous FIFO holding pending ALU requests.
// Ports:
//   clk, rst    : clock, synchronous active-high reset (empties the FIFO)
//   push        : write push_data when not full
//   push_data   : payload to store
//   pop         : drop the head entry when not empty
//   pop_data    : current head entry (valid whenever empty is low)
//   empty, full : status derived from the registered occupancy count
// A push arriving while full is ignored even if a pop happens in the same
// cycle, so full/empty never depend on the requests of the current cycle.
// -----------------------------------------------------------------------------
module req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 45
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign pop_data  = mem_r[rd_ptr_r];

    // Storage, pointers and occupancy count
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r <= (wr_ptr_r == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}}
                                                            : wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= (rd_ptr_r == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}}
                                                            : rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/alu_dispatch.sv
// -----------------------------------------------------------------------------
// alu_dispatch
// Queues ALU requests, presents one at a time to an external combinational
// ALU, captures its result and returns it with the requester's tag, strictly
// in request order.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid/req_ready      : request handshake
//   req_op, req_a, req_b     : opcode and operands of the request
//   req_tag                  : requester tag, echoed on rsp_tag
//   alu_a, alu_b, alu_ctrl   : registered operands/control to the ALU
//   alu_result, alu_zero     : ALU outputs (combinational from alu_*)
//   rsp_valid/rsp_ready      : response handshake
//   rsp_result, rsp_zero     : captured ALU outputs
//   rsp_illegal              : request used the reserved opcode
//   rsp_tag                  : tag of the answered request
//   ops_done                 : wrapping count of completed responses
// Sequencing: IDLE pops the FIFO head into the ALU operand registers, DRIVE
// gives the ALU one cycle and captures its outputs, RESP holds the response
// until accepted and may pop the next request on the accepting edge, which
// gives one response every two cycles under continuous acceptance.
// -----------------------------------------------------------------------------
module alu_dispatch
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [TAG_W-1:0]  req_tag,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_ctrl,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_illegal,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic [OPS_W-1:0]  ops_done
);

    state_e             state_r;
    state_e             next_state_s;
    logic               push_s;
    logic               pop_s;
    logic               handshake_s;
    logic               fifo_empty_s;
    logic               fifo_full_s;
    req_t               push_data_s;
    req_t               head_s;

    logic [DATA_W-1:0]  alu_a_r;
    logic [DATA_W-1:0]  alu_b_r;
    logic [OP_W-1:0]    alu_ctrl_r;
    logic [TAG_W-1:0]   tag_r;
    logic               rsp_valid_r;
    logic [DATA_W-1:0]  rsp_result_r;
    logic               rsp_zero_r;
    logic               rsp_illegal_r;
    logic [TAG_W-1:0]   rsp_tag_r;
    logic [OPS_W-1:0]   ops_done_r;

    // Ready comes only from the registered FIFO count, never from a pop in
    // the same cycle, so a full FIFO refuses a push even while draining.
    assign req_ready   = !fifo_full_s;
    assign push_s      = req_valid && req_ready;
    assign handshake_s = (state_r == ST_RESP) && rsp_ready;

    assign push_data_s.op  = req_op;
    assign push_data_s.a   = req_a;
    assign push_data_s.b   = req_b;
    assign push_data_s.tag = req_tag;

    req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PAYLOAD_W)
    ) u_req_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .pop_data  (head_s),
        .empty     (fifo_empty_s),
        .full      (fifo_full_s)
    );

    // Next-state and pop decision; empty reflects the registered count, so a
    // request pushed this cycle cannot be popped until the next one
    always_comb begin
        next_state_s = state_r;
        pop_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s        = 1'b1;
                    next_state_s = ST_DRIVE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                next_state_s = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    if (!fifo_empty_s) begin
                        pop_s        = 1'b1;
                        next_state_s = ST_DRIVE;
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end else begin
                    next_state_s = ST_RESP;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // ALU operand registers: loaded only on a pop, otherwise held
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a_r    <= {DATA_W{1'b0}};
            alu_b_r    <= {DATA_W{1'b0}};
            alu_ctrl_r <= {OP_W{1'b0}};
            tag_r      <= {TAG_W{1'b0}};
        end else if (pop_s) begin
            alu_a_r    <= head_s.a;
            alu_b_r    <= head_s.b;
            alu_ctrl_r <= head_s.op;
            tag_r      <= head_s.tag;
        end
    end

    // Response capture: written only in DRIVE, so fields stay frozen in RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_result_r  <= {DATA_W{1'b0}};
            rsp_zero_r    <= 1'b0;
            rsp_illegal_r <= 1'b0;
            rsp_tag_r     <= {TAG_W{1'b0}};
        end else if (state_r == ST_DRIVE) begin
            rsp_result_r  <= alu_result;
            rsp_zero_r    <= alu_zero;
            rsp_illegal_r <= is_reserved(alu_ctrl_r);
            rsp_tag_r     <= tag_r;
        end
    end

    // Registered response-valid flag, mirrors residence in RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_r <= 1'b0;
        end else begin
            rsp_valid_r <= (next_state_s == ST_RESP);
        end
    end

    // Completed-response counter, wraps naturally at its width
    always_ff @(posedge clk) begin
        if (rst) begin
            ops_done_r <= {OPS_W{1'b0}};
        end else if (handshake_s) begin
            ops_done_r <= ops_done_r + OPS_W'(1);
        end
    end

    assign alu_a       = alu_a_r;
    assign alu_b       = alu_b_r;
    assign alu_ctrl    = alu_ctrl_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_result  = rsp_result_r;
    assign rsp_zero    = rsp_zero_r;
    assign rsp_illegal = rsp_illegal_r;
    assign rsp_tag     = rsp_tag_r;
    assign ops_done    = ops_done_r;

endmodule

// File: tb/tb_alu_dispatch.sv
// -----------------------------------------------------------------------------
// tb_alu_dispatch
// Directed bench for alu_dispatch with a behavioural ALU attached to the
// alu_* ports. Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_alu_dispatch;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [18:0] req_a;
    logic [18:0] req_b;
    logic [3:0]  req_tag;
    logic [18:0] alu_a;
    logic [18:0] alu_b;
    logic [2:0]  alu_ctrl;
    logic [18:0] alu_result;
    logic        alu_zero;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [18:0] rsp_result;
    logic        rsp_zero;
    logic        rsp_illegal;
    logic [3:0]  rsp_tag;
    logic [15:0] ops_done;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [15:0] exp_ops     = 16'd0;

    // Directed operation table: op, a, b -> result, zero, illegal
    logic [2:0]  tbl_op  [8] = '{3'b000, 3'b111, 3'b000, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110};
    logic [18:0] tbl_a   [8] = '{19'd9, 19'd3, 19'd5, 19'd300, 19'd100, 19'h00F0F, 19'd3, 19'd256};
    logic [18:0] tbl_b   [8] = '{19'd9, 19'd4, 19'd7, 19'd400, 19'd0, 19'h000FF, 19'd4, 19'd3};
    logic [18:0] tbl_res [8] = '{19'd0, 19'd0, 19'h7FFFE, 19'd120000, 19'd33, 19'h0000F, 19'd48, 19'd32};
    logic        tbl_z   [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        tbl_ill [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    always #5 clk = ~clk;

    alu_dispatch dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_tag     (req_tag),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_ctrl    (alu_ctrl),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_zero    (rsp_zero),
        .rsp_illegal (rsp_illegal),
        .rsp_tag     (rsp_tag),
        .ops_done    (ops_done)
    );

    // Behavioural ALU
    logic [37:0] prod;
    always_comb begin
        prod       = {19'd0, alu_a} * {19'd0, alu_b};
        alu_result = 19'd0;
        case (alu_ctrl)
            3'b000:  alu_result = alu_a - alu_b;
            3'b001:  alu_result = alu_a + alu_b;
            3'b010:  alu_result = prod[18:0];
            3'b011:  alu_result = alu_a / 19'd3;
            3'b100:  alu_result = alu_a & alu_b;
            3'b101:  alu_result = alu_a << alu_b[4:0];
            3'b110:  alu_result = alu_a >> alu_b[4:0];
            default: alu_result = 19'd0;
        endcase
        alu_zero = (alu_result == 19'd0);
    end

    // Drive one request for one rising edge; called at a falling edge
    task automatic push(input logic [2:0] op, input logic [18:0] a,
                        input logic [18:0] b, input logic [3:0] tag);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_op = 3'd0; req_a = 19'd0; req_b = 19'd0; req_tag = 4'd0;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid got %0b want 0", rsp_valid); end
        vectors++;
        if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready got %0b want 1", req_ready); end
        vectors++;
        if (ops_done !== 16'd0) begin miscompares++; $display("FAIL reset_ops_done got %0d want 0", ops_done); end
        vectors++;
        if ({rsp_result, rsp_zero, rsp_illegal, rsp_tag} !== 25'd0) begin
            miscompares++; $display("FAIL reset_rsp_fields got %0h/%0b/%0b/%0h want 0", rsp_result, rsp_zero, rsp_illegal, rsp_tag);
        end
        vectors++;
        if ({alu_a, alu_b, alu_ctrl} !== 41'd0) begin
            miscompares++; $display("FAIL reset_alu_regs got %0h/%0h/%0h want 0", alu_a, alu_b, alu_ctrl);
        end
        rst = 1'b0;
        exp_ops = 16'd0;
    endtask

    task automatic test_single_add();
        rsp_ready = 1'b1;
        push(3'b001, 19'd5, 19'd7, 4'd3);      // accepted at E0
        vectors++;
        if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL add_valid_e0 got %0b want 0", rsp_valid); end
        @(negedge clk);                         // after E1: popped
        vectors++;
        if ({alu_a, alu_b, alu_ctrl} !== {19'd5, 19'd7, 3'b001}) begin
            miscompares++; $display("FAIL add_alu_drive got %0d/%0d/%0d want 5/7/1", alu_a, alu_b, alu_ctrl);
        end
        vectors++;
        if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL add_valid_e1 got %0b want 0", rsp_valid); end
        @(negedge clk);                         // after E2: captured
        vectors++;
        if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL add_valid_e2 got %0b want 1", rsp_valid); end
        vectors++;
        if ({rsp_result, rsp_zero, rsp_illegal, rsp_tag} !== {19'd12, 1'b0, 1'b0, 4'd3}) begin
            miscompares++; $display("FAIL add_rsp got %0d/%0b/%0b/%0d want 12/0/0/3", rsp_result, rsp_zero, rsp_illegal, rsp_tag);
        end
        @(negedge clk);                         // after E3: handshake done
        exp_ops = exp_ops + 16'd1;
        vectors++;
        if (ops_done !== exp_ops) begin miscompares++; $display("FAIL add_ops_done got %0d want %0d", ops_done, exp_ops); end
        vectors++;
        if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL add_valid_after got %0b want 0", rsp_valid); end
    endtask

    task automatic test_ops();
        logic got;
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push(tbl_op[i], tbl_a[i], tbl_b[i], 4'(i + 4));
            got = 1'b0;
            for (int c = 0; c < 20 && !got; c++) begin
                if (rsp_valid) got = 1'b1;
                else @(negedge clk);
            end
            vectors++;
            if (!got) begin
                miscompares++; $display("FAIL ops_timeout[%0d] got no rsp_valid want 1", i);
            end else begin
                vectors++;
                if ({rsp_result, rsp_zero, rsp_illegal, rsp_tag} !== {tbl_res[i], tbl_z[i], tbl_ill[i], 4'(i + 4)}) begin
                    miscompares++;
                    $display("FAIL ops_rsp[%0d] got %0h/%0b/%0b/%0d want %0h/%0b/%0b/%0d", i,
                             rsp_result, rsp_zero, rsp_illegal, rsp_tag, tbl_res[i], tbl_z[i], tbl_ill[i], i + 4);
                end
                vectors++;
                if (alu_ctrl !== tbl_op[i]) begin
                    miscompares++; $display("FAIL ops_ctrl_fwd[%0d] got %0b want %0b", i, alu_ctrl, tbl_op[i]);
                end
                @(negedge clk);
                exp_ops = exp_ops + 16'd1;
                vectors++;
                if (ops_done !== exp_ops) begin miscompares++; $display("FAIL ops_done[%0d] got %0d want %0d", i, ops_done, exp_ops); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic got;
        logic stale;
        rsp_ready = 1'b0;
        for (int t = 0; t < 5; t++) begin
            push(3'b001, 19'(t * 10), 19'd1, 4'(t));
        end
        // tag 0 in RESP, tags 1..4 fill the FIFO
        vectors++;
        if (req_ready !== 1'b0) begin miscompares++; $display("FAIL bp_full_ready got %0b want 0", req_ready); end
        // A sixth request (tag 15) is offered and must be refused throughout
        req_valid = 1'b1; req_op = 3'b001; req_a = 19'd7; req_b = 19'd7; req_tag = 4'd15;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if ({rsp_valid, rsp_result, rsp_tag, req_ready} !== {1'b1, 19'd1, 4'd0, 1'b0}) begin
                miscompares++; $display("FAIL bp_hold0[%0d] got v%0b r%0d t%0d rdy%0b want v1 r1 t0 rdy0", c, rsp_valid, rsp_result, rsp_tag, req_ready);
            end
        end
        // Full FIFO with a response handshake: still no push this cycle
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        exp_ops = exp_ops + 16'd1;
        vectors++;
        if (req_ready !== 1'b1) begin miscompares++; $display("FAIL fullpop_ready got %0b want 1", req_ready); end
        vectors++;
        if (ops_done !== exp_ops) begin miscompares++; $display("FAIL fullpop_ops got %0d want %0d", ops_done, exp_ops); end
        for (int t = 1; t < 5; t++) begin
            got = 1'b0;
            for (int c = 0; c < 20 && !got; c++) begin
                if (rsp_valid) got = 1'b1;
                else @(negedge clk);
            end
            vectors++;
            if (!got) begin
                miscompares++; $display("FAIL bp_timeout[%0d] got no rsp_valid want 1", t);
            end else begin
                for (int h = 0; h < 3; h++) begin
                    vectors++;
                    if ({rsp_valid, rsp_result, rsp_tag} !== {1'b1, 19'(t * 10 + 1), 4'(t)}) begin
                        miscompares++; $display("FAIL bp_rsp[%0d.%0d] got v%0b r%0d t%0d want v1 r%0d t%0d", t, h, rsp_valid, rsp_result, rsp_tag, t * 10 + 1, t);
                    end
                    if (h < 2) @(negedge clk);
                end
                rsp_ready = 1'b1;
                @(negedge clk);
                rsp_ready = 1'b0;
                exp_ops = exp_ops + 16'd1;
                vectors++;
                if (ops_done !== exp_ops) begin miscompares++; $display("FAIL bp_ops[%0d] got %0d want %0d", t, ops_done, exp_ops); end
            end
        end
        // Nothing else (in particular the refused tag 15) may come out
        stale = 1'b0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rsp_valid) stale = 1'b1;
        end
        vectors++;
        if (stale !== 1'b0) begin miscompares++; $display("FAIL bp_extra_rsp got tag %0d want none", rsp_tag); end
    endtask

    task automatic test_reset_mid();
        logic stale;
        rsp_ready = 1'b0;
        for (int t = 0; t < 4; t++) begin
            push(3'b001, 19'd2, 19'(t), 4'(t + 8));
        end
        vectors++;
        if ({rsp_valid, rsp_tag} !== {1'b1, 4'd8}) begin
            miscompares++; $display("FAIL rstmid_pre got v%0b t%0d want v1 t8", rsp_valid, rsp_tag);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_ops = 16'd0;
        vectors++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            miscompares++; $display("FAIL rstmid_flags got v%0b rdy%0b want v0 rdy1", rsp_valid, req_ready);
        end
        vectors++;
        if (ops_done !== 16'd0) begin miscompares++; $display("FAIL rstmid_ops got %0d want 0", ops_done); end
        vectors++;
        if ({rsp_tag, rsp_result, alu_a, alu_b} !== 61'd0) begin
            miscompares++; $display("FAIL rstmid_regs got t%0d r%0d a%0d b%0d want 0", rsp_tag, rsp_result, alu_a, alu_b);
        end
        stale = 1'b0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (rsp_valid) stale = 1'b1;
        end
        vectors++;
        if (stale !== 1'b0) begin miscompares++; $display("FAIL rstmid_stale got tag %0d want none", rsp_tag); end
    endtask

    task automatic test_wrap();
        logic got;
        force dut.ops_done_r = 16'hFFFE;
        #1;
        release dut.ops_done_r;
        exp_ops = 16'hFFFE;
        rsp_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            push(3'b001, 19'd1, 19'd1, 4'(k + 1));
            got = 1'b0;
            for (int c = 0; c < 20 && !got; c++) begin
                if (rsp_valid) got = 1'b1;
                else @(negedge clk);
            end
            vectors++;
            if (!got) begin
                miscompares++; $display("FAIL wrap_timeout[%0d] got no rsp_valid want 1", k);
            end else begin
                vectors++;
                if ({rsp_result, rsp_tag} !== {19'd2, 4'(k + 1)}) begin
                    miscompares++; $display("FAIL wrap_rsp[%0d] got r%0d t%0d want r2 t%0d", k, rsp_result, rsp_tag, k + 1);
                end
                @(negedge clk);
                exp_ops = exp_ops + 16'd1;
                vectors++;
                if (ops_done !== exp_ops) begin miscompares++; $display("FAIL wrap_ops[%0d] got %0h want %0h", k, ops_done, exp_ops); end
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_add();
        test_ops();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global time bound
    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
